// File: rtl/ring_meas_sched.sv
// ring_meas_sched: round-robin gated frequency measurement of pRINGS ring oscillators.
// Ports: i_clk/i_rst (sync, active-high); i_start/i_stop/i_cont/i_mask scan control;
// i_ring_gray async Gray count of selected ring; o_ring_sel/o_ring_en ring drive;
// o_busy, o_valid/o_idx/o_count result strobe. Define RING_MEAS_HOLD_EN to add the
// per-ring result file with i_rd_idx/o_rd_count (registered read, 1-cycle latency).
module ring_meas_sched #(
    parameter int pRINGS  = 4,
    parameter int pCNT_W  = 12,
    parameter int pSETTLE = 16,
    parameter int pGATE   = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_stop,
    input  logic                        i_cont,
    input  logic [pRINGS-1:0]           i_mask,
    input  logic [pCNT_W-1:0]           i_ring_gray,
`ifdef RING_MEAS_HOLD_EN
    input  logic [$clog2(pRINGS)-1:0]   i_rd_idx,
    output logic [pCNT_W-1:0]           o_rd_count,
`endif
    output logic [$clog2(pRINGS)-1:0]   o_ring_sel,
    output logic                        o_ring_en,
    output logic                        o_busy,
    output logic                        o_valid,
    output logic [$clog2(pRINGS)-1:0]   o_idx,
    output logic [pCNT_W-1:0]           o_count
);
    localparam int SW   = $clog2(pRINGS);
    localparam int CMAX = pGATE > pSETTLE ? pGATE : pSETTLE;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] SET_LAST  = CW'(pSETTLE - 1);
    localparam logic [CW-1:0] GATE_LAST = CW'(pGATE - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t            state_q;
    logic [pCNT_W-1:0] sync1_q, sync2_q, bin_d, b0_q, count_q;
    logic [pRINGS-1:0] mask_q;
    logic              cont_q, en_q, valid_q, has_next_d;
    logic [SW-1:0]     sel_q, idx_q, next_d;
    logic [CW-1:0]     cnt_q;

    function automatic logic [SW-1:0] lowest(input logic [pRINGS-1:0] m);
        lowest = '0;
        for (int i = pRINGS - 1; i >= 0; i--) if (m[i]) lowest = SW'(i);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) {sync2_q, sync1_q} <= '0;
        else       {sync2_q, sync1_q} <= {sync1_q, i_ring_gray};
    end

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < pCNT_W; i++) bin_d[i] = ^(sync2_q >> i);
    end

    // Lowest set mask bit strictly above the current ring.
    always_comb begin
        next_d     = '0;
        has_next_d = 1'b0;
        for (int i = pRINGS - 1; i >= 0; i--) begin
            if (mask_q[i] && i > int'(sel_q)) begin
                next_d     = SW'(i);
                has_next_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
            b0_q    <= '0;
            cnt_q   <= '0;
        end else if (i_stop) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && |i_mask) begin
                        mask_q  <= i_mask;
                        cont_q  <= i_cont;
                        sel_q   <= lowest(i_mask);
                        en_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        b0_q    <= bin_d;
                        cnt_q   <= '0;
                        state_q <= GATE;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                GATE: begin
                    if (cnt_q == GATE_LAST) begin
                        // Modular subtract absorbs counter wrap inside the window.
                        count_q <= bin_d - b0_q;
                        idx_q   <= sel_q;
                        valid_q <= 1'b1;
                        en_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    if (has_next_d || cont_q) begin
                        sel_q   <= has_next_d ? next_d : lowest(mask_q);
                        en_q    <= 1'b1;
                        state_q <= SETTLE;
                    end else state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RING_MEAS_HOLD_EN
    logic [pCNT_W-1:0] file_q [pRINGS];
    logic [pCNT_W-1:0] rd_q;

    // The result is written at the end of its o_valid cycle; a same-cycle
    // read of that index is forwarded so it sees the new value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < pRINGS; i++) file_q[i] <= '0;
            rd_q <= '0;
        end else begin
            if (valid_q) file_q[idx_q] <= count_q;
            rd_q <= (valid_q && i_rd_idx == idx_q) ? count_q : file_q[i_rd_idx];
        end
    end

    assign o_rd_count = rd_q;
`endif

    assign o_ring_sel = sel_q;
    assign o_ring_en  = en_q;
    assign o_busy     = state_q != IDLE;
    assign o_valid    = valid_q;
    assign o_idx      = idx_q;
    assign o_count    = count_q;
endmodule

// File: tb/tb_ring_meas_sched.sv
// tb_ring_meas_sched: table-driven scans with a result scoreboard for ring_meas_sched.
module tb_ring_meas_sched;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0, i_stop = 1'b0, i_cont = 1'b0;
    logic [3:0]  i_mask = '0;
    logic [11:0] i_ring_gray;
    logic [1:0]  o_ring_sel, o_idx;
    logic        o_ring_en, o_busy, o_valid;
    logic [11:0] o_count;
`ifdef RING_MEAS_HOLD_EN
    logic [1:0]  i_rd_idx = '0;
    logic [11:0] o_rd_count;
`endif

    ring_meas_sched #(.pRINGS(4), .pCNT_W(12), .pSETTLE(4), .pGATE(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_cont(i_cont), .i_mask(i_mask), .i_ring_gray(i_ring_gray),
`ifdef RING_MEAS_HOLD_EN
        .i_rd_idx(i_rd_idx), .o_rd_count(o_rd_count),
`endif
        .o_ring_sel(o_ring_sel), .o_ring_en(o_ring_en), .o_busy(o_busy),
        .o_valid(o_valid), .o_idx(o_idx), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Ring model: ring k advances by k+1 per clock while enabled.
    logic [11:0] rc [4];
    logic        preset_en = 1'b0;
    logic [11:0] preset_val = '0;
    logic [11:0] gsel;
    always @(posedge i_clk) begin
        if (i_rst) for (int k = 0; k < 4; k++) rc[k] <= '0;
        else if (preset_en) rc[0] <= preset_val;
        else if (o_ring_en) rc[o_ring_sel] <= rc[o_ring_sel] + 12'(o_ring_sel) + 12'd1;
    end
    assign gsel        = rc[o_ring_sel];
    assign i_ring_gray = gsel ^ (gsel >> 1);

    int passed = 0, total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    typedef struct { logic [1:0] idx; logic [11:0] cnt; int cyc; } exp_t;
    exp_t sb [$];
    exp_t e;

    always @(negedge i_clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected o_valid: got idx %0d count %0d at cycle %0d, want none", o_idx, o_count, cyc);
            end else begin
                e = sb.pop_front();
                chk("valid idx", int'(o_idx), int'(e.idx));
                chk("valid count", int'(o_count), int'(e.cnt));
                chk("valid cycle", cyc, e.cyc);
            end
        end
    end

    typedef struct { logic [3:0] mask; logic pre; logic [11:0] pre_val; int n; } vec_t;
    vec_t vecs [4];

    // Call at a negedge; start is held for one cycle (spec cycle t0).
    task automatic start_scan(input logic [3:0] m, input logic c, input int reps, output int t0);
        int j = 0;
        i_mask  = m;
        i_cont  = c;
        i_start = 1'b1;
        t0      = cyc;
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < 4; k++)
                if (m[k]) begin
                    j++;
                    sb.push_back('{2'(k), 12'(16 * (k + 1)), t0 + 21 * j});
                end
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int t_end);
        int lim = 0;
        while (o_busy && lim < 600) begin
            @(negedge i_clk);
            lim++;
        end
        chk("busy falls at cycle", cyc, t_end);
        chk("scoreboard drained", sb.size(), 0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        vecs[0] = '{4'b0101, 1'b0, 12'h000, 2};
        vecs[1] = '{4'b0001, 1'b1, 12'hFF8, 1};
        vecs[2] = '{4'b1111, 1'b0, 12'h000, 4};
        vecs[3] = '{4'b0110, 1'b0, 12'h000, 2};

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("reset busy", int'(o_busy), 0);
        chk("reset ring_en", int'(o_ring_en), 0);
        chk("reset valid", int'(o_valid), 0);
        chk("reset idx/sel", int'({o_idx, o_ring_sel}), 0);
        chk("reset count", int'(o_count), 0);

        i_start = 1'b1;
        i_mask  = 4'b0000;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        chk("zero mask start ignored", int'(o_busy), 0);

        foreach (vecs[v]) begin
            if (vecs[v].pre) begin
                preset_en  = 1'b1;
                preset_val = vecs[v].pre_val;
                @(negedge i_clk);
                preset_en = 1'b0;
            end
            start_scan(vecs[v].mask, 1'b0, 1, t0);
            chk("ring_en after start", int'(o_ring_en), 1);
            wait_until(t0 + 21 * vecs[v].n);
            chk("busy during last DONE", int'(o_busy), 1);
            wait_idle(t0 + 21 * vecs[v].n + 1);
            @(negedge i_clk);
        end

`ifdef RING_MEAS_HOLD_EN
        for (int k = 0; k < 4; k++) begin
            i_rd_idx = 2'(k);
            @(negedge i_clk);
            chk("hold read", int'(o_rd_count), 16 * (k + 1));
        end
`endif

        // Continuous scan of ring 3, start while busy, then stop mid-GATE.
        start_scan(4'b1000, 1'b1, 3, t0);
        wait_until(t0 + 30);
        i_start = 1'b1;
        i_mask  = 4'b0001;
        i_cont  = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_until(t0 + 70);
        chk("cont still busy", int'(o_busy), 1);
        chk("cont ring sel", int'(o_ring_sel), 3);
        i_stop = 1'b1;
        @(negedge i_clk);
        i_stop = 1'b0;
        chk("stop busy", int'(o_busy), 0);
        chk("stop ring_en", int'(o_ring_en), 0);
        chk("stop keeps idx", int'(o_idx), 3);
        chk("stop keeps count", int'(o_count), 64);
        repeat (40) @(negedge i_clk);
        chk("stop no further valid", sb.size(), 0);

        // Stop in the same cycle as start wins.
        i_start = 1'b1;
        i_stop  = 1'b1;
        i_mask  = 4'b1111;
        @(negedge i_clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        @(negedge i_clk);
        chk("start+stop busy", int'(o_busy), 0);

        // Reset during SETTLE.
        i_start = 1'b1;
        i_mask  = 4'b0001;
        t0      = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_until(t0 + 2);
        chk("pre-reset ring_en", int'(o_ring_en), 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid reset busy", int'(o_busy), 0);
        chk("mid reset ring_en", int'(o_ring_en), 0);
        chk("mid reset idx/sel", int'({o_idx, o_ring_sel}), 0);
        chk("mid reset count", int'(o_count), 0);
`ifdef RING_MEAS_HOLD_EN
        i_rd_idx = 2'd3;
        @(negedge i_clk);
        chk("hold cleared by reset", int'(o_rd_count), 0);
`endif
        repeat (40) @(negedge i_clk);
        chk("mid reset no valid", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
